// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory unit: FSM state encoding,
// byte width and wait-state counter sizing.
package dmem_pkg;

  localparam int BYTE_W   = 8;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W word storage with a byte-enabled synchronous write and a
// registered synchronous read port. Contents start as word i = i.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [IDX_W-1:0]         idx,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/BYTE_W-1:0] be,
  output logic [DATA_W-1:0]        rdata
);

  localparam int BE_W = DATA_W / BYTE_W;

  logic [DATA_W-1:0] words [DEPTH];

  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    // NOTE: storage words carry no reset; contents must survive rst_n, and
    // the declaration value only seeds the simulation/power-up image.
    logic [DATA_W-1:0] word_q = DATA_W'(w);

    // NOTE: state is always updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
      if (wr_en && (idx == IDX_W'(w))) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be[b]) word_q[b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
        end
      end
    end

    assign words[w] = word_q;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rdata <= words[idx];
  end

endmodule

// File: rtl/data_memory_unit.sv
// Single-outstanding data memory front end: request/response handshake,
// programmable wait states, alignment/range error decode around dmem_array.
module data_memory_unit
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [DATA_W/BYTE_W-1:0] req_be,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err
);

  localparam int BE_W  = DATA_W / BYTE_W;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = $clog2(DEPTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [BE_W-1:0]    be_q;

  logic               rsp_valid_q, rsp_err_q, rd_sel_q;

  logic               acc_we;
  logic [ADDR_W-1:0]  acc_addr;
  logic [DATA_W-1:0]  acc_wdata;
  logic [BE_W-1:0]    acc_be;
  logic [ADDR_W-1:0]  idx_full;
  logic               misaligned, out_range, acc_err;
  logic               accept, enter_resp, wr_en, rd_en;
  logic [DATA_W-1:0]  arr_rdata;

  assign req_ready = rst_n && (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  // With zero wait states the array is accessed on the accepting edge itself,
  // so the live request is used in IDLE and the latched copy elsewhere.
  assign acc_we    = (state_q == IDLE) ? req_we    : we_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign acc_be    = (state_q == IDLE) ? req_be    : be_q;

  assign idx_full   = acc_addr >> OFF_W;
  assign misaligned = (acc_addr & ADDR_W'(BE_W - 1)) != '0;
  assign out_range  = idx_full >= ADDR_W'(DEPTH);
  assign acc_err    = misaligned || out_range;

  assign enter_resp = (accept && (WAIT_STATES == 0)) ||
                      ((state_q == WAIT) && (cnt_q == '0));
  assign wr_en      = enter_resp &&  acc_we && !acc_err;
  assign rd_en      = enter_resp && !acc_we && !acc_err;

  // NOTE: every variable assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= acc_err;
        rd_sel_q    <= rd_en;
      end else if ((state_q == RESP) && rsp_ready) begin
        rsp_valid_q <= 1'b0;
        rsp_err_q   <= 1'b0;
        rd_sel_q    <= 1'b0;
      end
    end
  end

  // Request payload is only consumed after a valid accept, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .idx   (idx_full[IDX_W-1:0]),
    .wdata (acc_wdata),
    .be    (acc_be),
    .rdata (arr_rdata)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rd_sel_q ? arr_rdata : '0;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: one instance with two wait states and
// one with none, driven from a shared vector table plus reset/stall sequences.
module tb_data_memory_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: WAIT_STATES = 2
  logic        a_req_valid, a_req_ready, a_req_we;
  logic [31:0] a_req_addr, a_req_wdata;
  logic [3:0]  a_req_be;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_rsp_rdata;

  // Instance B: WAIT_STATES = 0
  logic        b_req_valid, b_req_ready, b_req_we;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [3:0]  b_req_be;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  data_memory_unit #(
    .DATA_W(32), .DEPTH(16), .ADDR_W(32), .WAIT_STATES(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  data_memory_unit #(
    .DATA_W(32), .DEPTH(16), .ADDR_W(32), .WAIT_STATES(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One full transaction with rsp_ready held high; lat counts edges after the
  // accepting edge up to the one where rsp_valid is first seen high.
  task automatic access(input bit on_b, input vec_t v,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    if (on_b) begin
      b_req_valid = 1'b1; b_req_we = v.we; b_req_addr = v.addr;
      b_req_wdata = v.wdata; b_req_be = v.be;
    end else begin
      a_req_valid = 1'b1; a_req_we = v.we; a_req_addr = v.addr;
      a_req_wdata = v.wdata; a_req_be = v.be;
    end
    @(posedge clk);
    #1;
    if (on_b) b_req_valid = 1'b0; else a_req_valid = 1'b0;
    lat = -1; rd = '0; er = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (on_b ? b_rsp_valid : a_rsp_valid) begin
        lat = k;
        rd  = on_b ? b_rsp_rdata : a_rsp_rdata;
        er  = on_b ? b_rsp_err   : a_rsp_err;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp_a(output bit got);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a_rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          got;
    vec_t        v;

    vecs[0]  = '{1'b0, 32'h14, 32'h0,        4'hF, 32'h5,        1'b0};
    vecs[1]  = '{1'b1, 32'h08, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 32'h08, 32'h0,        4'hF, 32'h00BB00DD, 1'b0};
    vecs[3]  = '{1'b0, 32'h06, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[4]  = '{1'b0, 32'h40, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, 32'h04, 32'h0,        4'hF, 32'h1,        1'b0};
    vecs[6]  = '{1'b1, 32'h0C, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'h0C, 32'h0,        4'hF, 32'h3,        1'b0};
    vecs[8]  = '{1'b1, 32'h3C, 32'h12345678, 4'hF, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'h3C, 32'h0,        4'hF, 32'h12345678, 1'b0};
    vecs[10] = '{1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 32'h0,        1'b1};
    vecs[11] = '{1'b1, 32'h02, 32'hDEADBEEF, 4'hF, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 32'h00, 32'h0,        4'hF, 32'h0,        1'b0};
    vecs[13] = '{1'b1, 32'h08, 32'h11223344, 4'hA, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 32'h08, 32'h0,        4'hF, 32'h11BB33DD, 1'b0};

    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst a req_ready", 32'(a_req_ready), 32'd0);
    check("rst a rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst a rsp_rdata", a_rsp_rdata, 32'd0);
    check("rst a rsp_err",   32'(a_rsp_err),   32'd0);
    check("rst b req_ready", 32'(b_req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-rst a req_ready", 32'(a_req_ready), 32'd1);
    check("post-rst b req_ready", 32'(b_req_ready), 32'd1);

    // Vector table on the two-wait-state instance
    for (int i = 0; i < 15; i++) begin
      access(1'b0, vecs[i], rd, er, lat);
      check($sformatf("a vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("a vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("a vec%0d latency", i), 32'(lat), 32'd3);
    end

    // First six vectors on the zero-wait-state instance
    for (int i = 0; i < 6; i++) begin
      access(1'b1, vecs[i], rd, er, lat);
      check($sformatf("b vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("b vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("b vec%0d latency", i), 32'(lat), 32'd1);
    end

    // Stalled response with a conflicting request held on the inputs
    a_rsp_ready = 1'b0;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h14; a_req_be = 4'hF;
    @(posedge clk);
    #1;
    a_req_we = 1'b1; a_req_wdata = 32'hFFFFFFFF;
    wait_rsp_a(got);
    check("stall rsp timeout", 32'(got), 32'd1);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall%0d rsp_valid", c), 32'(a_rsp_valid), 32'd1);
      check($sformatf("stall%0d rsp_rdata", c), a_rsp_rdata, 32'h5);
      check($sformatf("stall%0d rsp_err", c),   32'(a_rsp_err), 32'd0);
      check($sformatf("stall%0d req_ready", c), 32'(a_req_ready), 32'd0);
      @(negedge clk);
    end
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall release req_ready", 32'(a_req_ready), 32'd1);
    check("stall release rsp_valid", 32'(a_rsp_valid), 32'd0);
    v = '{1'b0, 32'h14, 32'h0, 4'hF, 32'h5, 1'b0};
    access(1'b0, v, rd, er, lat);
    check("ignored write rdata", rd, 32'h5);

    // Reset while in WAIT abandons the write
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h10;
    a_req_wdata = 32'hFFFFFFFF; a_req_be = 4'hF;
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst-wait req_ready", 32'(a_req_ready), 32'd0);
    check("rst-wait rsp_valid", 32'(a_rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst-wait release req_ready", 32'(a_req_ready), 32'd1);
    v = '{1'b0, 32'h10, 32'h0, 4'hF, 32'h4, 1'b0};
    access(1'b0, v, rd, er, lat);
    check("rst-wait read rdata", rd, 32'h4);
    check("rst-wait read latency", 32'(lat), 32'd3);

    // Reset while in RESP drops the response; memory keeps its contents
    a_rsp_ready = 1'b0;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h04; a_req_be = 4'hF;
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    wait_rsp_a(got);
    check("rst-resp rsp timeout", 32'(got), 32'd1);
    check("rst-resp pre rdata", a_rsp_rdata, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst-resp rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst-resp rsp_rdata", a_rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_rsp_ready = 1'b1;
    v = '{1'b0, 32'h3C, 32'h0, 4'hF, 32'h12345678, 1'b0};
    access(1'b0, v, rd, er, lat);
    check("mem survives reset a", rd, 32'h12345678);
    v = '{1'b0, 32'h08, 32'h0, 4'hF, 32'h00BB00DD, 1'b0};
    access(1'b1, v, rd, er, lat);
    check("mem survives reset b", rd, 32'h00BB00DD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_unit.md
DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits; SHALL be a power of two and at least 8.
REQ-002 Parameter DEPTH, default 16, number of words; SHALL be at least 2.
REQ-003 Parameter ADDR_W, default 32, byte-address width.
REQ-004 Parameter WAIT_STATES, default 1, extra access cycles, range 0..15.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  unit can accept a request.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_wdata  in  DATA_W  write data.
REQ-012 req_be  in  DATA_W/8  byte enables, write only.
REQ-013 rsp_valid  out  1  response present.
REQ-014 rsp_ready  in  1  consumer accepts response.
REQ-015 rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
REQ-016 rsp_err  out  1  misaligned or out-of-range access.

Function
REQ-017 The word index SHALL be req_addr shifted right by log2(DATA_W/8); the access is misaligned if the low log2(DATA_W/8) address bits are nonzero, and out of range if the index is DEPTH or more.
REQ-018 The FSM SHALL have the states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE with rst_n high.
REQ-019 In IDLE, if req_valid is 1, the unit SHALL latch we, addr, wdata and be, then go to RESP if WAIT_STATES=0, otherwise to WAIT with the counter loaded to WAIT_STATES-1.
REQ-020 In WAIT, the counter SHALL decrement each cycle; when it is 0, the next edge SHALL go to RESP.
REQ-021 rsp_valid SHALL rise exactly WAIT_STATES+1 cycles after the accepting edge.
REQ-022 On the edge entering RESP, a legal write SHALL update only the bytes whose be bit is 1, and a legal read SHALL capture mem[index] into rsp_rdata.
REQ-023 An error access SHALL leave memory unchanged and SHALL give rsp_err=1 and rsp_rdata=0.
REQ-024 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL stay stable until rsp_ready=1; the handshake edge SHALL return to IDLE and clear rsp_valid.
REQ-025 A request SHALL NOT be accepted on a response-handshake edge, so throughput is at most one access per WAIT_STATES+2 cycles.
REQ-026 A write with be all zero SHALL be legal: it leaves memory unchanged and gives a normal response.
REQ-027 The request inputs SHALL be ignored outside IDLE.
REQ-028 With a single outstanding access, a read SHALL always see every previously responded write.

Reset
REQ-029 While rst_n is low, the unit SHALL hold the state at IDLE, the counter at 0, rsp_valid, rsp_rdata and rsp_err at 0, and req_ready at 0.
REQ-030 A reset during WAIT SHALL abandon the access, with no memory write.
REQ-031 A reset during RESP SHALL drop the pending response.
REQ-032 Memory contents SHALL NOT be affected by reset; the simulation initial contents SHALL be word i = i.
REQ-033 req_ready SHALL be 1 on the first rising edge after rst_n deasserts.

Structure
REQ-034 Package dmem_pkg SHALL hold the state enum (IDLE, WAIT, RESP) and the byte-width and counter-width constants.
REQ-035 Storage SHALL be the sub-module dmem_array: a DEPTH x DATA_W array with a byte-enabled synchronous write and a synchronous read.
REQ-036 The FSM, counter and error decode SHALL reside in data_memory_unit.

Verification (DATA_W=32, DEPTH=16, WAIT_STATES=2)
REQ-037 Scenario: read addr 0x14 after reset -> rsp_valid high 3 cycles after accept, rsp_rdata=5, rsp_err=0.
REQ-038 Scenario: write addr 0x08, wdata 0xAABBCCDD, be=0101, then read 0x08 -> 0x00BB00DD (old word 2 = 0x00000002 yields 0x00BB00DD).
REQ-039 Scenario: read addr 0x06 (misaligned) and read addr 0x40 (index 16) -> rsp_err=1, rsp_rdata=0; a following read of 0x04 -> 1.
REQ-040 Scenario: hold rsp_ready=0 for 5 cycles -> response stable and req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-041 Scenario: write 0x10 with 0xFFFFFFFF, assert rst_n low during WAIT, release, read 0x10 -> 4 (write abandoned).
REQ-042 Scenario: repeat with WAIT_STATES=0 -> rsp_valid 1 cycle after accept.
